// File: rtl/issue_scheduler.sv
// In-order issue scheduler: allocates ROB tags and tracks ROB, RS and LSB occupancy.
// Optional sticky underflow flag sched_err is built only when ISSUE_SCHED_ERR_EN is defined.
module issue_scheduler #(
    parameter int ROB_WIDTH = 4,
    parameter int ROB_SIZE  = 16,
    parameter int RS_SIZE   = 8,
    parameter int LSB_SIZE  = 8,
    parameter int RS_W      = $clog2(RS_SIZE + 1),
    parameter int LSB_W     = $clog2(LSB_SIZE + 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 if_valid,
    input  logic                 if_is_mem,
    output logic                 if_ready,
    output logic                 dec_issue,
    output logic [ROB_WIDTH-1:0] dec_tag,
    input  logic                 rob_commit,
    input  logic                 rs_free,
    input  logic                 lsb_free,
    output logic [ROB_WIDTH:0]   rob_count,
    output logic [RS_W-1:0]      rs_cnt,
    output logic [LSB_W-1:0]     lsb_cnt,
    output logic                 stall,
`ifdef ISSUE_SCHED_ERR_EN
    output logic                 sched_err,
`endif
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [ROB_WIDTH:0] ROB_FULL = (ROB_WIDTH + 1)'(ROB_SIZE);
    localparam logic [RS_W-1:0]    RS_FULL  = RS_W'(RS_SIZE);
    localparam logic [LSB_W-1:0]   LSB_FULL = LSB_W'(LSB_SIZE);

    state_t                 state;
    logic                   flush_cnt;
    logic [ROB_WIDTH-1:0]   tail;
    logic                   accept;
    logic                   rob_rel, rs_rel, lsb_rel;
    logic                   rs_inc, lsb_inc;
    logic [ROB_WIDTH:0]     rob_next;
    logic [RS_W-1:0]        rs_next;
    logic [LSB_W-1:0]       lsb_next;

    // Handshake: an instruction transfers in any cycle where if_valid && if_ready;
    // if_valid may drop without a transfer and if_ready carries no memory of it.
    assign if_ready = rdy_in && !clear && (state != FLUSH) && (rob_count < ROB_FULL) &&
                      (if_is_mem ? (lsb_cnt < LSB_FULL) : (rs_cnt < RS_FULL));
    assign accept   = if_valid && if_ready;
    assign state_dbg = state;

    // Releases against an empty counter are dropped so the counters never wrap below zero.
    assign rob_rel = rob_commit && (rob_count != '0);
    assign rs_rel  = rs_free && (rs_cnt != '0);
    assign lsb_rel = lsb_free && (lsb_cnt != '0);
    assign rs_inc  = accept && !if_is_mem;
    assign lsb_inc = accept && if_is_mem;

    always_comb begin
        rob_next = rob_count;
        rs_next  = rs_cnt;
        lsb_next = lsb_cnt;
        if (accept && !rob_rel)      rob_next = rob_count + (ROB_WIDTH + 1)'(1);
        else if (!accept && rob_rel) rob_next = rob_count - (ROB_WIDTH + 1)'(1);
        if (rs_inc && !rs_rel)       rs_next = rs_cnt + RS_W'(1);
        else if (!rs_inc && rs_rel)  rs_next = rs_cnt - RS_W'(1);
        if (lsb_inc && !lsb_rel)     lsb_next = lsb_cnt + LSB_W'(1);
        else if (!lsb_inc && lsb_rel) lsb_next = lsb_cnt - LSB_W'(1);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= RUN;
            flush_cnt <= 1'b0;
            tail      <= '0;
            rob_count <= '0;
            rs_cnt    <= '0;
            lsb_cnt   <= '0;
            dec_issue <= 1'b0;
            dec_tag   <= '0;
            stall     <= 1'b0;
        end else if (!rdy_in) begin
            dec_issue <= 1'b0;
        end else if (clear) begin
            state     <= FLUSH;
            flush_cnt <= 1'b0;
            tail      <= '0;
            rob_count <= '0;
            rs_cnt    <= '0;
            lsb_cnt   <= '0;
            dec_issue <= 1'b0;
            stall     <= 1'b0;
        end else begin
            dec_issue <= accept;
            if (accept) begin
                dec_tag <= tail;
                tail    <= tail + ROB_WIDTH'(1);
            end
            rob_count <= rob_next;
            rs_cnt    <= rs_next;
            lsb_cnt   <= lsb_next;
            case (state)
                RUN: begin
                    if (if_valid && !if_ready) begin
                        state <= STALL;
                        stall <= 1'b1;
                    end
                end
                STALL: begin
                    if (if_ready || !if_valid) begin
                        state <= RUN;
                        stall <= 1'b0;
                    end
                end
                FLUSH: begin
                    // flush_cnt marks the second FLUSH cycle; leave after it.
                    if (flush_cnt) begin
                        state     <= RUN;
                        flush_cnt <= 1'b0;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    stall <= 1'b0;
                end
            endcase
        end
    end

`ifdef ISSUE_SCHED_ERR_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sched_err <= 1'b0;
        end else if (rdy_in && !clear &&
                     ((rob_commit && rob_count == '0) ||
                      (rs_free && rs_cnt == '0) ||
                      (lsb_free && lsb_cnt == '0))) begin
            sched_err <= 1'b1;
        end
    end
`endif

endmodule
